// File: rtl/spio_hss_pkt_flush_fifo_pkg.sv
// Shared types and constants for the per-channel packet flush FIFO.
// Packet width matches the multiplexer's packet port width.
package spio_hss_pkt_flush_fifo_pkg;

  localparam int unsigned PKT_BITS      = 72;
  localparam int unsigned PFF_DROP_BITS = 32;

  typedef enum logic [1:0] {
    PFF_ST_RUN     = 2'd0,
    PFF_ST_FLUSH   = 2'd1,
    PFF_ST_DISCARD = 2'd2
  } pff_state_t;

  function automatic logic [PFF_DROP_BITS-1:0] pff_sat_add(
    input logic [PFF_DROP_BITS-1:0] a,
    input logic [PFF_DROP_BITS-1:0] b
  );
    logic [PFF_DROP_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PFF_DROP_BITS] ? '1 : s[PFF_DROP_BITS-1:0];
  endfunction

endpackage

// File: rtl/spio_hss_pkt_flush_fifo_mem.sv
// Simple dual-port packet RAM: synchronous write, registered read with enable, no reset.
module spio_hss_pkt_flush_fifo_mem
  import spio_hss_pkt_flush_fifo_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned DATA_BITS = PKT_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [DATA_BITS-1:0] i_wr_data,
  input  logic                 i_rd_en,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [DATA_BITS-1:0] o_rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [DATA_BITS-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/spio_hss_pkt_flush_fifo.sv
// Per-channel packet FIFO that flushes and sinks traffic after a prolonged link loss.
// Optional drop/high-water statistics: define SPIO_HSS_PKT_FIFO_STATS_EN.
module spio_hss_pkt_flush_fifo
  import spio_hss_pkt_flush_fifo_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 4,
  parameter int unsigned TIMEOUT      = 256,
  parameter int unsigned TIMEOUT_BITS = 9
) (
  input  logic                     CLK_IN,
  input  logic                     RESET_IN,
  input  logic                     LINK_UP_IN,
  input  logic [PKT_BITS-1:0]      IN_DATA_IN,
  input  logic                     IN_VLD_IN,
  output logic                     IN_RDY_OUT,
  output logic [PKT_BITS-1:0]      OUT_DATA_OUT,
  output logic                     OUT_VLD_OUT,
  input  logic                     OUT_RDY_IN,
  output logic                     FLUSHING_OUT,
  output logic [PFF_DROP_BITS-1:0] DROP_COUNT_OUT,
  output logic [ADDR_BITS:0]       HIGH_WATER_OUT
);

  localparam int unsigned      CW    = ADDR_BITS + 1;
  localparam logic [CW-1:0]    FULL  = CW'(2 ** ADDR_BITS);
  localparam logic [TIMEOUT_BITS-1:0] TMO = TIMEOUT_BITS'(TIMEOUT);

  pff_state_t             r_state;
  logic [ADDR_BITS-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]          r_count;
  logic [TIMEOUT_BITS-1:0] r_timer;
  logic                   r_in_rdy, r_out_vld;
  logic                   r_byp;
  logic [PKT_BITS-1:0]    r_byp_data;

  logic                   w_wr, w_push, w_pop, w_head_upd, w_byp_sel;
  logic [CW-1:0]          w_cnt_nxt;
  logic [ADDR_BITS-1:0]   w_rptr_nxt;
  logic [TIMEOUT_BITS-1:0] w_timer_nxt;
  logic [PKT_BITS-1:0]    w_mem_rdata;

  assign w_wr       = IN_VLD_IN & r_in_rdy;
  assign w_push     = w_wr & (r_state == PFF_ST_RUN);
  assign w_pop      = r_out_vld & OUT_RDY_IN & (r_state == PFF_ST_RUN);
  assign w_rptr_nxt = r_rptr + ADDR_BITS'(w_pop);
  assign w_cnt_nxt  = (r_state == PFF_ST_RUN) ? r_count + CW'(w_push) - CW'(w_pop) : '0;

  // The head only reloads when it actually changes, so OUT_DATA holds its last value
  // when empty; a write landing on the new head slot is forwarded around the RAM.
  assign w_head_upd = (w_pop && (w_cnt_nxt != '0)) || (w_push && (r_count == '0));
  assign w_byp_sel  = w_push && (w_rptr_nxt == r_wptr);

  assign w_timer_nxt = LINK_UP_IN ? '0 : ((r_timer == TMO) ? TMO : r_timer + 1'b1);

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      r_state    <= PFF_ST_RUN;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_timer    <= '0;
      r_in_rdy   <= 1'b0;
      r_out_vld  <= 1'b0;
      r_byp      <= 1'b1;
      r_byp_data <= '0;
    end else begin
      r_timer <= w_timer_nxt;
      case (r_state)
        PFF_ST_RUN: begin
          r_wptr  <= r_wptr + ADDR_BITS'(w_push);
          r_rptr  <= w_rptr_nxt;
          r_count <= w_cnt_nxt;
          if (w_head_upd) r_byp <= w_byp_sel;
          if (w_byp_sel) r_byp_data <= IN_DATA_IN;
          if (w_timer_nxt == TMO) begin
            r_state   <= PFF_ST_FLUSH;
            r_in_rdy  <= 1'b0;
            r_out_vld <= 1'b0;
          end else begin
            r_in_rdy  <= (w_cnt_nxt != FULL);
            r_out_vld <= (w_cnt_nxt != '0);
          end
        end
        PFF_ST_FLUSH: begin
          r_wptr    <= '0;
          r_rptr    <= '0;
          r_count   <= '0;
          r_in_rdy  <= 1'b1;
          r_out_vld <= 1'b0;
          r_state   <= PFF_ST_DISCARD;
        end
        PFF_ST_DISCARD: begin
          r_in_rdy  <= 1'b1;
          r_out_vld <= 1'b0;
          if (LINK_UP_IN) r_state <= PFF_ST_RUN;
        end
        default: r_state <= PFF_ST_RUN;
      endcase
    end
  end

  spio_hss_pkt_flush_fifo_mem #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (PKT_BITS)
  ) u_mem (
    .i_clk     (CLK_IN),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wptr),
    .i_wr_data (IN_DATA_IN),
    .i_rd_en   (w_head_upd),
    .i_rd_addr (w_rptr_nxt),
    .o_rd_data (w_mem_rdata)
  );

  assign IN_RDY_OUT   = r_in_rdy;
  assign OUT_VLD_OUT  = r_out_vld;
  assign OUT_DATA_OUT = r_byp ? r_byp_data : w_mem_rdata;
  assign FLUSHING_OUT = (r_state == PFF_ST_FLUSH) || (r_state == PFF_ST_DISCARD);

`ifdef SPIO_HSS_PKT_FIFO_STATS_EN
  logic [PFF_DROP_BITS-1:0] r_drop;
  logic [ADDR_BITS:0]       r_hw;
  logic [PFF_DROP_BITS-1:0] w_drop_inc;

  always_comb begin
    w_drop_inc = '0;
    case (r_state)
      PFF_ST_FLUSH:   w_drop_inc = PFF_DROP_BITS'(r_count);
      PFF_ST_DISCARD: w_drop_inc = PFF_DROP_BITS'(w_wr);
      default:        w_drop_inc = '0;
    endcase
  end

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      r_drop <= '0;
      r_hw   <= '0;
    end else begin
      r_drop <= pff_sat_add(r_drop, w_drop_inc);
      if (w_cnt_nxt > r_hw) r_hw <= w_cnt_nxt;
    end
  end

  assign DROP_COUNT_OUT = r_drop;
  assign HIGH_WATER_OUT = r_hw;
`else
  assign DROP_COUNT_OUT = '0;
  assign HIGH_WATER_OUT = '0;
`endif

endmodule
